// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad entry block: key codes, debounce FSM states,
// the matrix-position to key-code map and the two-digit entry shift helper.
package keypad_pkg;

  localparam logic [3:0] KEY_A    = 4'd10;
  localparam logic [3:0] KEY_B    = 4'd11;
  localparam logic [3:0] KEY_C    = 4'd12;
  localparam logic [3:0] KEY_D    = 4'd13;
  localparam logic [3:0] KEY_STAR = 4'd14;
  localparam logic [3:0] KEY_HASH = 4'd15;

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD} state_t;

  function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'd0:    code = 4'd1;
      4'd1:    code = 4'd2;
      4'd2:    code = 4'd3;
      4'd3:    code = KEY_A;
      4'd4:    code = 4'd4;
      4'd5:    code = 4'd5;
      4'd6:    code = 4'd6;
      4'd7:    code = KEY_B;
      4'd8:    code = 4'd7;
      4'd9:    code = 4'd8;
      4'd10:   code = 4'd9;
      4'd11:   code = KEY_C;
      4'd12:   code = KEY_STAR;
      4'd13:   code = 4'd0;
      4'd14:   code = KEY_HASH;
      default: code = KEY_D;
    endcase
    return code;
  endfunction

  // Keeps only the newest digit before shifting, so the result stays within 0..99.
  function automatic logic [6:0] next_entry(input logic [6:0] entry, input logic [3:0] digit);
    logic [6:0] low;
    low = entry % 7'd10;
    return 7'(low * 7'd10) + {3'b000, digit};
  endfunction

endpackage

// File: rtl/keypad_scanner.sv
// Keypad row scanner: synchronizes the columns, walks the row drive and
// reports one NONE/SINGLE result at the end of every full 4-row scan.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 1024
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [3:0] Col_n,
  output logic [3:0] Row_n,
  output logic       scan_done,
  output logic       scan_single,
  output logic [3:0] scan_code
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [3:0]       r_col_meta;
  logic [3:0]       r_col_sync;
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_row;
  logic [1:0]       r_hits;
  logic [3:0]       r_code;

  logic             w_slot_end;
  logic [3:0]       w_active;
  logic [2:0]       w_row_hits;
  logic [1:0]       w_col_idx;
  logic [3:0]       w_row_code;
  logic [2:0]       w_total;

  assign w_slot_end = (r_div == DIV_LAST);
  assign w_active   = ~r_col_sync;
  assign w_row_hits = {2'b00, w_active[0]} + {2'b00, w_active[1]}
                    + {2'b00, w_active[2]} + {2'b00, w_active[3]};
  assign w_col_idx  = w_active[0] ? 2'd0 : w_active[1] ? 2'd1 : w_active[2] ? 2'd2 : 2'd3;
  assign w_row_code = key_lookup(r_row, w_col_idx);
  // Hits saturate at 2: any multi-key scan is a ghost and reads as NONE.
  assign w_total    = {1'b0, r_hits} + w_row_hits;

  assign Row_n       = ~(4'b0001 << r_row);
  assign scan_done   = w_slot_end && (r_row == 2'd3);
  assign scan_single = (w_total == 3'd1);
  assign scan_code   = (w_row_hits == 3'd1) ? w_row_code : r_code;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_col_meta <= 4'hF;
      r_col_sync <= 4'hF;
      r_div      <= '0;
      r_row      <= 2'd0;
      r_hits     <= 2'd0;
      r_code     <= 4'd0;
    end else begin
      r_col_meta <= Col_n;
      r_col_sync <= r_col_meta;
      if (w_slot_end) begin
        r_div <= '0;
        r_row <= r_row + 2'd1;
        if (r_row == 2'd3) begin
          r_hits <= 2'd0;
          r_code <= 4'd0;
        end else begin
          r_hits <= (w_total >= 3'd2) ? 2'd2 : w_total[1:0];
          if (w_row_hits == 3'd1) r_code <= w_row_code;
        end
      end else begin
        r_div <= r_div + 1'b1;
      end
    end
  end

endmodule

// File: rtl/keypad_entry.sv
// Keypad entry top: debounces scan results into single key events and builds a
// two-digit decimal value committed with '#'. Optional KEYPAD_ECHO_EN adds Entry.
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 1024,
  parameter int DEBOUNCE_SCANS = 8,
  parameter int MAX_VALUE      = 99
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [3:0] Col_n,
  output logic [3:0] Row_n,
  output logic [3:0] Key_code,
  output logic       Key_valid,
  output logic [6:0] Value,
  output logic       Valid
`ifdef KEYPAD_ECHO_EN
  ,
  output logic [6:0] Entry
`endif
);

  localparam logic [7:0] DEB  = 8'(DEBOUNCE_SCANS);
  localparam logic [6:0] MAXV = 7'(MAX_VALUE);

  logic       w_scan_done;
  logic       w_scan_single;
  logic [3:0] w_scan_code;

  state_t     r_state;
  logic [3:0] r_cand;
  logic [7:0] r_cnt;
  logic [7:0] r_rel;
  logic [3:0] r_key_code;
  logic       r_key_valid;
  logic [6:0] r_entry;
  logic [1:0] r_digits;
  logic [6:0] r_value;
  logic       r_valid;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV)) u_scanner (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .Col_n       (Col_n),
    .Row_n       (Row_n),
    .scan_done   (w_scan_done),
    .scan_single (w_scan_single),
    .scan_code   (w_scan_code)
  );

  // Debounce FSM; only moves on scan boundaries.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_state     <= IDLE;
      r_cand      <= 4'd0;
      r_cnt       <= 8'd0;
      r_rel       <= 8'd0;
      r_key_code  <= 4'd0;
      r_key_valid <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      if (w_scan_done) begin
        case (r_state)
          IDLE: begin
            if (w_scan_single) begin
              r_state <= DEBOUNCE;
              r_cand  <= w_scan_code;
              r_cnt   <= 8'd1;
            end
          end
          DEBOUNCE: begin
            if (w_scan_single && (w_scan_code == r_cand)) begin
              if (8'(r_cnt + 8'd1) >= DEB) begin
                r_state     <= HELD;
                r_cnt       <= 8'd0;
                r_rel       <= 8'd0;
                r_key_code  <= r_cand;
                r_key_valid <= 1'b1;
              end else begin
                r_cnt <= r_cnt + 8'd1;
              end
            end else begin
              r_state <= IDLE;
              r_cnt   <= 8'd0;
            end
          end
          HELD: begin
            if (w_scan_single) begin
              r_rel <= 8'd0;
            end else if (8'(r_rel + 8'd1) >= DEB) begin
              r_state <= IDLE;
              r_rel   <= 8'd0;
            end else begin
              r_rel <= r_rel + 8'd1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_entry  <= 7'd0;
      r_digits <= 2'd0;
      r_value  <= 7'd0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (r_key_valid) begin
        if (r_key_code <= 4'd9) begin
          r_entry  <= next_entry(r_entry, r_key_code);
          r_digits <= (r_digits == 2'd2) ? 2'd2 : r_digits + 2'd1;
        end else if (r_key_code == KEY_STAR) begin
          r_entry  <= 7'd0;
          r_digits <= 2'd0;
        end else if (r_key_code == KEY_HASH) begin
          r_value  <= (r_entry > MAXV) ? MAXV : r_entry;
          r_valid  <= 1'b1;
          r_entry  <= 7'd0;
          r_digits <= 2'd0;
        end
      end
    end
  end

  assign Key_code  = r_key_code;
  assign Key_valid = r_key_valid;
  assign Value     = r_value;
  assign Valid     = r_valid;
`ifdef KEYPAD_ECHO_EN
  assign Entry     = r_entry;
`endif

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: a keypad model drives the columns from the row drive,
// and timed key/commit events are queued at stimulus time and matched at output.
module tb_keypad_entry;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] col_n, col_n50;
  logic [3:0] row_n, row_n50;
  logic [3:0] key_code, key_code50;
  logic       key_valid, key_valid50;
  logic [6:0] value, value50;
  logic       valid, valid50;
`ifdef KEYPAD_ECHO_EN
  logic [6:0] entry, entry50;
`endif

  logic [15:0] press_mask;
  int          n;
  int          checks = 0;
  int          failures = 0;
  int          model_entry = 0;

  logic [19:0] exp_key_q[$];
  logic [22:0] exp_val_q[$];
  logic [22:0] exp_val50_q[$];

  logic [3:0] key_tab [16] = '{4'd1, 4'd2, 4'd3, 4'd10,
                              4'd4, 4'd5, 4'd6, 4'd11,
                              4'd7, 4'd8, 4'd9, 4'd12,
                              4'd14, 4'd0, 4'd15, 4'd13};

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_n) n <= 0;
    else        n <= n + 1;
  end

  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (press_mask[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
  end

  always_comb begin
    col_n50 = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (press_mask[r*4+c] && !row_n50[r]) col_n50[c] = 1'b0;
  end

  keypad_entry #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3), .MAX_VALUE(99)) dut (
    .Clk(clk), .Rst_n(rst_n), .Col_n(col_n), .Row_n(row_n),
    .Key_code(key_code), .Key_valid(key_valid), .Value(value), .Valid(valid)
`ifdef KEYPAD_ECHO_EN
    , .Entry(entry)
`endif
  );

  keypad_entry #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3), .MAX_VALUE(50)) dut50 (
    .Clk(clk), .Rst_n(rst_n), .Col_n(col_n50), .Row_n(row_n50),
    .Key_code(key_code50), .Key_valid(key_valid50), .Value(value50), .Valid(valid50)
`ifdef KEYPAD_ECHO_EN
    , .Entry(entry50)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_scan_start();
    @(negedge clk);
    while (n % 16 != 0) @(negedge clk);
  endtask

  // Expected events carry the cycle stamp: Key_valid 48 cycles after the press
  // starts on a scan boundary (third matching scan end + 1), Valid one later.
  task automatic expect_key(input int t, input int idx);
    logic [3:0] code;
    int         v;
    code = key_tab[idx];
    exp_key_q.push_back({16'(t + 48), code});
    if (code <= 4'd9) begin
      model_entry = (model_entry % 10) * 10 + int'(code);
    end else if (code == 4'd14) begin
      model_entry = 0;
    end else if (code == 4'd15) begin
      v = (model_entry > 99) ? 99 : model_entry;
      exp_val_q.push_back({16'(t + 49), 7'(v)});
      v = (model_entry > 50) ? 50 : model_entry;
      exp_val50_q.push_back({16'(t + 49), 7'(v)});
      model_entry = 0;
    end
  endtask

  task automatic press(input int row, input int col, input int scans, input int rel_scans);
    wait_scan_start();
    press_mask = 16'(1) << (row * 4 + col);
    if (scans >= 3) expect_key(n, row * 4 + col);
    repeat (scans * 16) @(negedge clk);
    press_mask = 16'd0;
    repeat (rel_scans * 16) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    press_mask = 16'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_row_n", {28'd0, row_n}, 32'b1110);
    check("reset_value", {25'd0, value}, 32'd0);
    check("reset_valid", {31'd0, valid}, 32'd0);
    check("reset_key_valid", {31'd0, key_valid}, 32'd0);
    check("reset_key_code", {28'd0, key_code}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      logic [3:0] exp_row;
      while (n != 4 * i) @(negedge clk);
      exp_row = 4'hF;
      exp_row[i] = 1'b0;
      check("row_walk", {28'd0, row_n}, {28'd0, exp_row});
    end

    fork
      forever begin
        @(negedge clk);
        if (key_valid) begin
          check("key_pending", exp_key_q.size(), 1);
          if (exp_key_q.size() > 0) check("key_event", {12'd0, n[15:0], key_code}, {12'd0, exp_key_q.pop_front()});
        end
        if (valid) begin
          check("val_pending", exp_val_q.size(), 1);
          if (exp_val_q.size() > 0) check("value_event", {9'd0, n[15:0], value}, {9'd0, exp_val_q.pop_front()});
        end
        if (valid50) begin
          check("val50_pending", exp_val50_q.size(), 1);
          if (exp_val50_q.size() > 0) check("value50_event", {9'd0, n[15:0], value50}, {9'd0, exp_val50_q.pop_front()});
        end
      end
    join_none

    // Held '5' for 6 scans: a single event, no repeats.
    press(1, 1, 6, 4);
    check("key_code_after_release", {28'd0, key_code}, 32'd5);

    // Bounce on '7': 2 scans, gap, then 3 scans.
    wait_scan_start();
    press_mask = 16'(1) << 8;
    repeat (32) @(negedge clk);
    press_mask = 16'd0;
    repeat (16) @(negedge clk);
    press_mask = 16'(1) << 8;
    expect_key(n, 8);
    repeat (48) @(negedge clk);
    press_mask = 16'd0;
    repeat (64) @(negedge clk);

    // '4','2','#' -> 42 (older buffered digits drop out)
    press(1, 0, 3, 4);
    press(0, 1, 3, 4);
    press(3, 2, 3, 4);
    // '1','2','3','#' -> 23
    press(0, 0, 3, 4);
    press(0, 1, 3, 4);
    press(0, 2, 3, 4);
    press(3, 2, 3, 4);
    // '9','*','#' -> 0
    press(2, 2, 3, 4);
    press(3, 0, 3, 4);
    press(3, 2, 3, 4);
    // 'A' leaves the entry alone; '8','7','#' -> 87, clamped to 50 on dut50
    press(2, 1, 3, 4);
    press(0, 3, 3, 4);
    press(2, 0, 3, 4);
    press(3, 2, 3, 4);

    // Ghost: '1' and '6' together must not produce an event.
    wait_scan_start();
    press_mask = 16'(1) | (16'(1) << 6);
    repeat (80) @(negedge clk);
    press_mask = 16'd0;
    repeat (64) @(negedge clk);

    // '3','8' then commit.
    press(0, 2, 3, 4);
    press(2, 1, 3, 4);
`ifdef KEYPAD_ECHO_EN
    check("entry_echo", {25'd0, entry}, model_entry);
`endif
    press(3, 2, 3, 4);
`ifdef KEYPAD_ECHO_EN
    check("entry_after_commit", {25'd0, entry}, model_entry);
`endif

    repeat (64) @(negedge clk);
    check("key_q_drained", exp_key_q.size(), 0);
    check("val_q_drained", exp_val_q.size(), 0);
    check("val50_q_drained", exp_val50_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keypad_entry.md
Name: keypad_entry

Overview:
- Input-side counterpart of the board's 4-digit seven-segment display driver.
- Scans a 4x4 matrix keypad, debounces key presses and reports one event per press.
- Assembles decimal digit presses into a 0..99 value and commits it on Enter; the committed value feeds the display's Cn/Ti operands.

Parameters:
- SCAN_DIV, 1024: clocks each row is driven; must be >= 4.
- DEBOUNCE_SCANS, 8: consecutive identical full scans needed to accept a press; also the number of consecutive no-key scans needed to accept a release; range 1..255.
- MAX_VALUE, 99: commit clamp; range 0..99.

Ports:
- Clk  in  1  system clock.
- Rst_n  in  1  synchronous active-low reset.
- Col_n  in  4  keypad columns, active-low, pulled up, asynchronous.
- Row_n  out  4  keypad row drive, one-hot-low.
- Key_code  out  4  last accepted key code.
- Key_valid  out  1  one-cycle pulse per accepted press.
- Value  out  7  committed binary value, 0..MAX_VALUE.
- Valid  out  1  one-cycle pulse when Value updates.

Behaviour:
- Interface: one clock, Clk; reset is synchronous and active-low, Rst_n.
- Reset values:
  - Row_n=4'b1110 (row 0 driven).
  - Key_code, Key_valid, Value, Valid, entry buffer and all counters = 0.
  - FSM = IDLE.
- Column input: Col_n passes through a 2-FF synchronizer.
- Row scanning:
  - Row r is driven low for SCAN_DIV cycles, then row r+1; row 3 wraps to row 0.
  - One full scan is 4*SCAN_DIV cycles.
  - Synchronized columns are sampled on the last cycle of each row slot.
- Key map (row,col -> code):
  - Row 0: 1 2 3 A -> 1, 2, 3, 10.
  - Row 1: 4 5 6 B -> 4, 5, 6, 11.
  - Row 2: 7 8 9 C -> 7, 8, 9, 12.
  - Row 3: * 0 # D -> 14, 0, 15, 13.
- Scan result at the end of row 3:
  - SINGLE(code) if exactly one key was seen across all 4 slots.
  - NONE if zero keys were seen.
  - Two or more keys (same or different rows) count as NONE (ghost rejection).
- FSM (advances only at a scan end):
  - IDLE: SINGLE(c) -> DEBOUNCE with cand=c, cnt=1.
  - DEBOUNCE, on SINGLE(cand): cnt++.
    - When cnt reaches DEBOUNCE_SCANS, go to HELD.
    - In the next cycle, Key_code<=cand and Key_valid=1 for exactly one cycle.
    - With DEBOUNCE_SCANS=1, the press is accepted at the first scan end after leaving IDLE.
  - DEBOUNCE, on any other result: back to IDLE, cnt=0.
  - HELD: NONE increments rel_cnt; SINGLE clears rel_cnt; rel_cnt==DEBOUNCE_SCANS -> IDLE.
  - Holding a key produces no repeat events.
- Entry buffer: 7-bit entry plus 2-bit digit count. Updated in the cycle after Key_valid.
  - Digit d (0..9): entry = (entry % 10)*10 + d. The oldest digit drops after two digits, so entry never exceeds 99.
  - '*' (14): entry=0.
  - '#' (15): Value = min(entry, MAX_VALUE), Valid=1 for one cycle, entry=0. Committing with an empty entry gives Value=0.
  - A-D (10..13): reported on Key_code only; entry is unchanged.
- Latency from the scan end that completes debounce: Key_valid at +1 cycle, Valid/Value at +2 cycles.
- Reset during any state returns every output and counter to its reset value on the next Clk edge; a partial entry is discarded.

Optional Feature:
- Macro: KEYPAD_ECHO_EN.
- Defined:
  - Adds output port Entry (7 bits) = live entry buffer, so digits can be echoed on the display before commit.
  - Entry resets to 0 and follows every buffer update in the same cycle.
- Undefined: no Entry port; behaviour is otherwise identical.

Decomposition:
- Package keypad_pkg:
  - Key code constants KEY_A..KEY_D=10..13, KEY_STAR=14, KEY_HASH=15.
  - FSM state enum IDLE/DEBOUNCE/HELD.
  - Row-col to code lookup function.
- One sub-module, keypad_scanner:
  - Contains the synchronizer, row counter/driver and per-scan result generation.
  - Outputs scan_done, scan_single, scan_code.
- Debounce FSM and entry buffer stay in the top module.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=3, full scan=16 cycles):
- Reset with Rst_n=0 for 2 cycles -> Row_n=4'b1110, Value=0, Valid=0, Key_valid=0; Row_n walks 1110,1101,1011,0111 at 4-cycle steps.
- Hold key '5' (row1,col1) for 6 scans, then release -> exactly one Key_valid with Key_code=5, one cycle after the 3rd matching scan end; no second pulse while held.
- Bounce: '7' for 2 scans, none for 1 scan, '7' for 3 scans -> one Key_valid (Key_code=7), asserted only after the second run.
- Press '4','2','#' with full releases between -> Valid one cycle, Value=42; pressing '1','2','3','#' gives Value=23.
- '9','*','#' -> Value=0. With MAX_VALUE=50: '8','7','#' -> Value=50.
- Press '1' and '6' together for 5 scans -> no Key_valid. With KEYPAD_ECHO_EN: '3','8' -> Entry=38 before '#', Entry=0 after commit.
